router_pkt_ctrl: RTL and testbench

Packet-level write controller for the router's three output FIFOs (16 x 8 each). Parses the incoming byte stream (header, payload, parity), steers each byte into the destination FIFO with a per-port write enable, and back-pressures the source while the target FIFO is full. It also checks packet parity and issues a per-port soft reset when a non-empty FIFO goes unread for too long.

---
 rtl/router_pkg.sv | 31 +++
 rtl/router_timeout.sv | 45 ++++
 rtl/router_pkt_ctrl.sv | 140 ++++++++++++++
 tb/tb_router_pkt_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet write controller.
// Header layout: addr in [1:0], payload length in [7:2].
package router_pkg;

  localparam int NUM_PORTS   = 3;
  localparam int TIMEOUT_DEF = 30;

  localparam logic [1:0] ADDR_INVALID = 2'd3;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_e;

  // One-hot port select; the reserved address maps to no port.
  function automatic logic [NUM_PORTS-1:0] port_sel(input logic [1:0] addr);
    logic [NUM_PORTS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr == 2'(i)) sel[i] = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/router_timeout.sv
// Per-port unread watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of a non-empty FIFO that is not being read.
module router_timeout
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic fifo_empty,
  input  logic read_enb,
  output logic soft_reset
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_reset_q, soft_reset_d;

  always_comb begin
    cnt_d        = cnt_q;
    soft_reset_d = 1'b0;
    if (read_enb || fifo_empty) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
      cnt_d        = '0;
      soft_reset_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_pkt_ctrl.sv
// Packet write controller: parses header/payload/parity, steers bytes into
// one of the output FIFOs, stalls on full, flags parity/header/abort errors.
module router_pkt_ctrl
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [7:0]           data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic [7:0]           fifo_data,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 err
);

  localparam int LEN_W = LEN_MSB - LEN_LSB + 1;

  state_e               state_q, state_d;
  logic [1:0]           dest_q, dest_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [7:0]           par_q, par_d;
  logic                 err_q, err_d;

  logic [1:0]           hdr_addr;
  logic [LEN_W-1:0]     hdr_len;
  logic                 hdr_ok;
  logic [NUM_PORTS-1:0] hdr_sel, dest_sel, soft_reset_w;
  logic                 abort;
  logic                 busy_c;
  logic [NUM_PORTS-1:0] we_c;

  assign hdr_addr = data_in[ADDR_MSB:ADDR_LSB];
  assign hdr_len  = data_in[LEN_MSB:LEN_LSB];
  assign hdr_ok   = (hdr_addr != ADDR_INVALID) && (hdr_len != '0);
  assign hdr_sel  = port_sel(hdr_addr);
  assign dest_sel = port_sel(dest_q);
  assign abort    = |(soft_reset_w & dest_sel);

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    rem_d   = rem_q;
    par_d   = par_q;
    err_d   = 1'b0;
    busy_c  = 1'b0;
    we_c    = '0;
    case (state_q)
      IDLE: begin
        if (hdr_ok) busy_c = |(fifo_full & hdr_sel);
        if (pkt_valid && !busy_c) begin
          if (hdr_ok) begin
            we_c    = hdr_sel;
            dest_d  = hdr_addr;
            rem_d   = hdr_len;
            par_d   = data_in;
            state_d = PAYLOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (abort) begin
          busy_c  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          busy_c = |(fifo_full & dest_sel);
          if (pkt_valid && !busy_c) begin
            we_c  = dest_sel;
            par_d = par_q ^ data_in;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (abort) begin
          busy_c  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          busy_c = |(fifo_full & dest_sel);
          if (pkt_valid && !busy_c) begin
            // Parity byte is still written so downstream sees the whole packet.
            we_c    = dest_sel;
            err_d   = (data_in != par_q);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!resetn) begin
      busy_c = 1'b0;
      we_c   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      dest_q  <= '0;
      rem_q   <= '0;
      par_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      rem_q   <= rem_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timeout
    router_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk        (clk),
      .resetn     (resetn),
      .fifo_empty (fifo_empty[i]),
      .read_enb   (read_enb[i]),
      .soft_reset (soft_reset_w[i])
    );
  end

  assign write_enb  = we_c;
  assign busy       = busy_c;
  assign fifo_data  = data_in;
  assign vld_out    = ~fifo_empty;
  assign soft_reset = soft_reset_w;
  assign err        = err_q;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Directed bench for router_pkt_ctrl: packet steering, stalls, header and
// parity errors, unread timeout, abort and mid-packet reset.
module tb_router_pkt_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic [2:0] write_enb;
  logic [7:0] fifo_data;
  logic       busy;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  router_pkt_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .read_enb   (read_enb),
    .write_enb  (write_enb),
    .fifo_data  (fifo_data),
    .busy       (busy),
    .vld_out    (vld_out),
    .soft_reset (soft_reset),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h (failure %0d)", tag, obs, exp, fail_cnt);
    end
  endtask

  // Advance one clock: inputs change and outputs are sampled just after negedge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [2:0] exp_we, input string tag);
    pkt_valid = 1'b1;
    data_in   = d;
    #1;
    chk({tag, "_we"}, 32'(write_enb), 32'(exp_we));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_data"}, 32'(fifo_data), 32'(d));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         first;
    int         hi;
    logic [2:0] others;
    logic [7:0] par;
    logic [7:0] b;

    // Reset with hostile inputs
    resetn     = 1'b0;
    pkt_valid  = 1'b1;
    data_in    = 8'h09;
    fifo_full  = 3'b111;
    fifo_empty = 3'b111;
    read_enb   = 3'b000;
    #1;
    chk("rst_we", 32'(write_enb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_softrst", 32'(soft_reset), 32'd0);
    chk("rst_vld", 32'(vld_out), 32'd0);
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    fifo_full = 3'b000;
    tick();

    // Basic packet to port 1
    send_byte(8'h09, 3'b010, "t1_hdr");
    send_byte(8'hA5, 3'b010, "t1_p0");
    send_byte(8'h3C, 3'b010, "t1_p1");
    send_byte(8'h90, 3'b010, "t1_par");
    pkt_valid = 1'b0;
    #1;
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_idle_we", 32'(write_enb), 32'd0);

    // Same packet, stalled 3 cycles on the first payload byte
    send_byte(8'h09, 3'b010, "t2_hdr");
    pkt_valid = 1'b1;
    data_in   = 8'hA5;
    fifo_full = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_stall_busy", 32'(busy), 32'd1);
      chk("t2_stall_we", 32'(write_enb), 32'd0);
      tick();
    end
    fifo_full = 3'b000;
    send_byte(8'hA5, 3'b010, "t2_p0");
    send_byte(8'h3C, 3'b010, "t2_p1");
    send_byte(8'h90, 3'b010, "t2_par");
    pkt_valid = 1'b0;
    #1;
    chk("t2_err", 32'(err), 32'd0);

    // Invalid address header, then a good packet to port 0
    pkt_valid = 1'b1;
    data_in   = 8'h07;
    fifo_full = 3'b111;
    #1;
    chk("t3_bad_we", 32'(write_enb), 32'd0);
    chk("t3_bad_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_bad_err", 32'(err), 32'd1);
    fifo_full = 3'b000;
    send_byte(8'h04, 3'b001, "t3_hdr");
    chk("t3_err_width", 32'(err), 32'd0);
    send_byte(8'h55, 3'b001, "t3_p0");
    send_byte(8'h51, 3'b001, "t3_par");
    pkt_valid = 1'b0;
    #1;
    chk("t3_err", 32'(err), 32'd0);

    // Zero-length header is dropped with an error
    pkt_valid = 1'b1;
    data_in   = 8'h01;
    fifo_full = 3'b010;
    #1;
    chk("t3_len0_we", 32'(write_enb), 32'd0);
    chk("t3_len0_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_len0_err", 32'(err), 32'd1);

    // Valid header to a full port stalls in IDLE without error
    data_in   = 8'h06;
    fifo_full = 3'b100;
    #1;
    chk("t3_hdrfull_busy", 32'(busy), 32'd1);
    chk("t3_hdrfull_we", 32'(write_enb), 32'd0);
    tick();
    chk("t3_hdrfull_err", 32'(err), 32'd0);
    fifo_full = 3'b000;

    // Port 2 packet with wrong parity (correct would be 0x17)
    send_byte(8'h06, 3'b100, "t4_hdr");
    send_byte(8'h11, 3'b100, "t4_p0");
    send_byte(8'h00, 3'b100, "t4_par");
    pkt_valid = 1'b0;
    #1;
    chk("t4_err", 32'(err), 32'd1);
    tick();
    chk("t4_err_width", 32'(err), 32'd0);

    // Maximum length packet to port 2
    par = 8'hFE;
    send_byte(8'hFE, 3'b100, "t63_hdr");
    for (int i = 0; i < 63; i++) begin
      b   = 8'(i * 3 + 1);
      par = par ^ b;
      send_byte(b, 3'b100, "t63_pay");
    end
    send_byte(par, 3'b100, "t63_par");
    pkt_valid = 1'b0;
    #1;
    chk("t63_err", 32'(err), 32'd0);
    send_byte(8'h04, 3'b001, "t63_next_hdr");
    send_byte(8'h55, 3'b001, "t63_next_p0");
    send_byte(8'h51, 3'b001, "t63_next_par");
    pkt_valid = 1'b0;
    #1;
    chk("t63_next_err", 32'(err), 32'd0);

    // Unread timeout on port 0, no reads
    fifo_empty = 3'b110;
    #1;
    chk("t5_vld", 32'(vld_out), 32'b001);
    first  = -1;
    hi     = 0;
    others = 3'b000;
    for (int c = 0; c < 40; c++) begin
      tick();
      others = others | (soft_reset & 3'b110);
      if (soft_reset[0]) begin
        hi++;
        if (first < 0) first = c + 1;
      end
    end
    chk("t5_first", 32'(first), 32'd30);
    chk("t5_width", 32'(hi), 32'd1);
    chk("t5_others", 32'(others), 32'd0);

    // Read at cycle 15 restarts the count
    fifo_empty = 3'b111;
    tick();
    fifo_empty = 3'b110;
    first = -1;
    hi    = 0;
    for (int c = 0; c < 60; c++) begin
      read_enb = (c == 15) ? 3'b001 : 3'b000;
      tick();
      if (soft_reset[0]) begin
        hi++;
        if (first < 0) first = c + 1;
      end
    end
    chk("t5r_first", 32'(first), 32'd46);
    chk("t5r_width", 32'(hi), 32'd1);
    read_enb   = 3'b000;
    fifo_empty = 3'b111;
    tick();

    // Soft reset of the destination port aborts a packet mid-payload
    fifo_empty = 3'b110;
    send_byte(8'h14, 3'b001, "t5a_hdr");
    pkt_valid = 1'b0;
    for (int c = 0; c < 40 && !soft_reset[0]; c++) tick();
    chk("t5a_softrst", 32'(soft_reset[0]), 32'd1);
    pkt_valid = 1'b1;
    data_in   = 8'h22;
    #1;
    chk("t5a_busy", 32'(busy), 32'd1);
    chk("t5a_we", 32'(write_enb), 32'd0);
    tick();
    chk("t5a_err", 32'(err), 32'd1);
    chk("t5a_softrst_width", 32'(soft_reset), 32'd0);
    fifo_empty = 3'b111;
    send_byte(8'h04, 3'b001, "t5a_hdr2");
    send_byte(8'h55, 3'b001, "t5a_p0");
    send_byte(8'h51, 3'b001, "t5a_par");
    pkt_valid = 1'b0;
    #1;
    chk("t5a_err2", 32'(err), 32'd0);

    // Reset in the middle of a payload
    send_byte(8'h14, 3'b001, "t6_hdr");
    send_byte(8'h01, 3'b001, "t6_p0");
    resetn    = 1'b0;
    pkt_valid = 1'b1;
    data_in   = 8'h02;
    #1;
    chk("t6_rst_we", 32'(write_enb), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    tick();
    resetn    = 1'b1;
    pkt_valid = 1'b0;
    #1;
    chk("t6_err", 32'(err), 32'd0);
    send_byte(8'h09, 3'b010, "t6_hdr2");
    send_byte(8'hA5, 3'b010, "t6_p0b");
    send_byte(8'h3C, 3'b010, "t6_p1b");
    send_byte(8'h90, 3'b010, "t6_par");
    pkt_valid = 1'b0;
    #1;
    chk("t6_err2", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
